// File: rtl/disp_scan_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
// The leading-zero-blank helper exists only when DISP_LZB_EN is defined.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_RESET = 4'b1110;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  points;
    logic [3:0]  les;
  } disp_word_t;

`ifdef DISP_LZB_EN
  // Digit idx is blank when it and every more-significant nibble are zero; digit 0 always shows.
  function automatic logic lzb_blank(input logic [15:0] hex, input logic [1:0] idx);
    logic blank;
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (hex[15:4] == '0);
      2'd2:    blank = (hex[15:8] == '0);
      2'd3:    blank = (hex[15:12] == '0);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction
`endif

endpackage

// File: rtl/disp_scan_if.sv
// Host-side load channel of the display scanner: content write strobe and frame-update pulse.
interface disp_scan_if;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        load;
  logic        frame;

  modport master (output hexs, points, les, load, input frame);
  modport slave  (input hexs, points, les, load, output frame);
endinterface

// File: rtl/disp_scan_tick.sv
// Free-running scan prescaler; tick marks the last clock of each digit slot.
module scan_tick #(
  parameter int unsigned DIV_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [DIV_W-1:0] cnt,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign tick = &cnt_q;

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment scanner with double-buffered content and ghost blanking.
// Optional leading-zero blanking is built when DISP_LZB_EN is defined.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned DIV_W     = 17,
  parameter int unsigned GHOST_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  disp_scan_if.slave            host,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [3:0]            HEX,
  output logic                  point,
  output logic                  LE
);

  localparam logic [DIV_W-1:0] GHOST = DIV_W'(GHOST_CYC);

  logic [DIV_W-1:0]      cnt;
  logic                  tick;
  logic                  boundary;
  logic                  lzb;

  logic [1:0]            idx_q, idx_d;
  disp_word_t            pend_q, pend_d;
  disp_word_t            active_q, active_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  frame_q, frame_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            hex_q, hex_d;
  logic                  point_q, point_d;
  logic                  le_q, le_d;

  scan_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

`ifdef DISP_LZB_EN
  assign lzb = lzb_blank(active_q.hex, idx_q);
`else
  assign lzb = 1'b0;
`endif

  always_comb begin
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    frame_d      = 1'b0;
    boundary     = tick && (idx_q == 2'd3);

    if (tick) idx_d = idx_q + 2'd1;

    // Transfer takes the old pending word; a coincident load then refills pending.
    if (boundary && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
      frame_d      = 1'b1;
    end
    if (host.load) begin
      pend_d       = {host.hexs, host.points, host.les};
      pend_valid_d = 1'b1;
    end

    an_d    = ~(NUM_DIGITS'(1) << idx_q);
    hex_d   = active_q.hex[{idx_q, 2'b00} +: 4];
    point_d = active_q.points[idx_q];
    le_d    = active_q.les[idx_q] | (cnt < GHOST) | lzb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      frame_q      <= 1'b0;
      an_q         <= AN_RESET;
      hex_q        <= '0;
      point_q      <= 1'b0;
      le_q         <= 1'b1;
    end else begin
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      point_q      <= point_d;
      le_q         <= le_d;
    end
  end

  assign AN         = an_q;
  assign HEX        = hex_q;
  assign point      = point_q;
  assign LE         = le_q;
  assign host.frame = frame_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV_W = 4 (16-clock slots, 64-clock frames) and GHOST_CYC = 2.
module tb_disp_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] AN, HEX;
  logic       point, LE;

  disp_scan_if bus ();

  disp_scan #(.DIV_W(4), .GHOST_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus),
    .AN    (AN),
    .HEX   (HEX),
    .point (point),
    .LE    (LE)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int k = 0;          // rising edges since reset release
  int frame_k = -1;   // edge after which frame is expected high
  logic [15:0] e_hex = '0;
  logic [3:0]  e_pts = '0;
  logic [3:0]  e_les = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
  endtask

  // After edge k the outputs reflect prescaler/index as they were before that edge.
  task automatic check_cycle();
    int s, ph;
    logic [3:0] an_e, hex_e;
    logic le_e;
    s     = ((k - 1) / 16) % 4;
    ph    = (k - 1) % 16;
    hex_e = 4'((e_hex >> (4 * s)) & 16'h000F);
    an_e  = ~(4'(1) << s);
    le_e  = e_les[s] | (ph < 2);
`ifdef DISP_LZB_EN
    if (s != 0 && (e_hex >> (4 * s)) == 16'h0000) le_e = 1'b1;
`endif
    chk("AN", 16'(AN), 16'(an_e));
    chk("HEX", 16'(HEX), 16'(hex_e));
    chk("point", 16'(point), 16'(e_pts[s]));
    chk("LE", 16'(LE), 16'(le_e));
    chk("frame", 16'(bus.frame), 16'(k == frame_k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check_cycle();
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic load_word(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    bus.hexs   = h;
    bus.points = p;
    bus.les    = l;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    bus.hexs   = 16'hDEAD;
    bus.points = 4'hF;
    bus.les    = 4'hF;
  endtask

  task automatic chk_reset();
    chk("rst_AN", 16'(AN), 16'h000E);
    chk("rst_HEX", 16'(HEX), 16'h0000);
    chk("rst_point", 16'(point), 16'h0000);
    chk("rst_LE", 16'(LE), 16'h0001);
    chk("rst_frame", 16'(bus.frame), 16'h0000);
  endtask

  initial begin
    bus.hexs   = 16'hDEAD;
    bus.points = 4'hF;
    bus.les    = 4'hF;
    bus.load   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    k = 0;

    // Idle scan with blank content; no frame pulse without a pending load.
    run_to(64);

    // Mid-frame load, shown from the next frame.
    run_to(80);
    load_word(16'h1234, 4'b0101, 4'b0000);
    frame_k = 128;
    run_to(128);
    e_hex = 16'h1234; e_pts = 4'b0101; e_les = 4'b0000;

    // Two loads in one frame: last write wins.
    run_to(140);
    load_word(16'hAAAA, 4'b0000, 4'b0000);
    run_to(150);
    load_word(16'h5555, 4'b1010, 4'b0000);
    frame_k = 192;
    run_to(192);
    e_hex = 16'h5555; e_pts = 4'b1010; e_les = 4'b0000;

    // Load landing on the boundary edge stays pending for one more frame.
    run_to(200);
    load_word(16'h1234, 4'b0011, 4'b0000);
    run_to(255);
    frame_k = 256;
    load_word(16'hBEEF, 4'b1100, 4'b0010);
    e_hex = 16'h1234; e_pts = 4'b0011; e_les = 4'b0000;
    frame_k = 320;
    run_to(320);
    e_hex = 16'hBEEF; e_pts = 4'b1100; e_les = 4'b0010;

    // Leading-zero content.
    run_to(330);
    load_word(16'h0007, 4'b0000, 4'b0000);
    frame_k = 384;
    run_to(384);
    e_hex = 16'h0007; e_pts = 4'b0000; e_les = 4'b0000;
    run_to(450);
    load_word(16'h0000, 4'b0000, 4'b0000);
    frame_k = 512;
    run_to(512);
    e_hex = 16'h0000;
    run_to(552);

    // Asynchronous reset in slot 2.
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    k = 0;
    frame_k = -1;
    e_hex = '0; e_pts = '0; e_les = '0;
    run_to(130);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
